// File: rtl/traffic_demand_scheduler.sv
// Demand-actuated highway/farm-road phase scheduler: highway green by default,
// farm road served on a latched vehicle call or pedestrian request.
module traffic_demand_scheduler #(
  parameter int GREEN_MIN_HW   = 50,
  parameter int FARM_MAX_GREEN = 40,
  parameter int FARM_GAP       = 8,
  parameter int YELLOW_CYCLES  = 10,
  parameter int ALLRED_CYCLES  = 2,
  parameter int WALK_CYCLES    = 20,
  parameter int CNT_WIDTH      = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       farm_car_i,
  input  logic       ped_req_i,
  output logic       hw_green_o,
  output logic       hw_yellow_o,
  output logic       hw_red_o,
  output logic       farm_green_o,
  output logic       farm_yellow_o,
  output logic       farm_red_o,
  output logic       ped_walk_o,
  output logic [2:0] phase_o
);

  typedef enum logic [2:0] {
    S_HW_GREEN    = 3'd0,
    S_HW_YELLOW   = 3'd1,
    S_ALLRED_A    = 3'd2,
    S_FARM_GREEN  = 3'd3,
    S_FARM_YELLOW = 3'd4,
    S_ALLRED_B    = 3'd5
  } state_e;

  localparam logic [CNT_WIDTH-1:0] HW_MIN_LAST = CNT_WIDTH'(GREEN_MIN_HW - 1);
  localparam logic [CNT_WIDTH-1:0] FMAX_LAST   = CNT_WIDTH'(FARM_MAX_GREEN - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD    = CNT_WIDTH'(FARM_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] YEL_LAST    = CNT_WIDTH'(YELLOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] AR_LAST     = CNT_WIDTH'(ALLRED_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WALK_LAST   = CNT_WIDTH'(WALK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WALK_LEN    = CNT_WIDTH'(WALK_CYCLES);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic                 farm_call_q, farm_call_d;
  logic                 ped_pending_q, ped_pending_d;
  logic                 walk_flag_q, walk_flag_d;

  logic max_green, gap_out, enter_farm, leave_farm, state_chg;

  assign max_green = (timer_q == FMAX_LAST);
  // The walk window holds off gap-out but never max green.
  assign gap_out   = (gap_q == '0) && !farm_car_i &&
                     (!walk_flag_q || (timer_q >= WALK_LAST));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= S_HW_GREEN;
      timer_q       <= '0;
      gap_q         <= '0;
      farm_call_q   <= 1'b0;
      ped_pending_q <= 1'b0;
      walk_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      farm_call_q   <= farm_call_d;
      ped_pending_q <= ped_pending_d;
      walk_flag_q   <= walk_flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HW_GREEN:
        if ((timer_q >= HW_MIN_LAST) && (farm_call_q || ped_pending_q)) state_d = S_HW_YELLOW;
      S_HW_YELLOW:   if (timer_q == YEL_LAST)     state_d = S_ALLRED_A;
      S_ALLRED_A:    if (timer_q == AR_LAST)      state_d = S_FARM_GREEN;
      S_FARM_GREEN:  if (max_green || gap_out)    state_d = S_FARM_YELLOW;
      S_FARM_YELLOW: if (timer_q == YEL_LAST)     state_d = S_ALLRED_B;
      S_ALLRED_B:    if (timer_q == AR_LAST)      state_d = S_HW_GREEN;
      default:                                    state_d = S_HW_GREEN;
    endcase
  end

  assign state_chg  = (state_d != state_q);
  assign enter_farm = (state_q != S_FARM_GREEN) && (state_d == S_FARM_GREEN);
  assign leave_farm = (state_q == S_FARM_GREEN) && (state_d != S_FARM_GREEN);

  always_comb begin
    timer_d       = timer_q;
    gap_d         = gap_q;
    farm_call_d   = farm_call_q;
    ped_pending_d = ped_pending_q;
    walk_flag_d   = walk_flag_q;

    if (state_chg) begin
      timer_d = '0;
    end else if (state_q == S_HW_GREEN) begin
      if (timer_q < HW_MIN_LAST) timer_d = timer_q + 1'b1;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end

    // Requests seen on the entering edge are served by that entry.
    if (enter_farm) begin
      farm_call_d   = 1'b0;
      ped_pending_d = 1'b0;
      walk_flag_d   = ped_pending_q | ped_req_i;
      gap_d         = GAP_LOAD;
    end else begin
      if (farm_car_i && (state_q != S_FARM_GREEN)) farm_call_d = 1'b1;
      if (ped_req_i) ped_pending_d = 1'b1;
      if (leave_farm) walk_flag_d = 1'b0;
      if (state_q == S_FARM_GREEN) begin
        if (farm_car_i)        gap_d = GAP_LOAD;
        else if (gap_q != '0)  gap_d = gap_q - 1'b1;
      end
    end
  end

  always_comb begin
    hw_green_o    = 1'b0;
    hw_yellow_o   = 1'b0;
    hw_red_o      = 1'b1;
    farm_green_o  = 1'b0;
    farm_yellow_o = 1'b0;
    farm_red_o    = 1'b1;
    case (state_q)
      S_HW_GREEN:    begin hw_green_o    = 1'b1; hw_red_o   = 1'b0; end
      S_HW_YELLOW:   begin hw_yellow_o   = 1'b1; hw_red_o   = 1'b0; end
      S_FARM_GREEN:  begin farm_green_o  = 1'b1; farm_red_o = 1'b0; end
      S_FARM_YELLOW: begin farm_yellow_o = 1'b1; farm_red_o = 1'b0; end
      default: ;
    endcase
  end

  assign ped_walk_o = walk_flag_q && (state_q == S_FARM_GREEN) && (timer_q < WALK_LEN);
  assign phase_o    = state_q;

endmodule
